cdb_arbiter: RTL and testbench

Shares the common data bus (CDB) among the backend functional units: integer ALU, multiply/divide, branch, and load return path. Each requester writes its completed result into a private shallow FIFO. Every cycle, a rotating-priority arbiter grants up to CDB_WIDTH FIFO heads and registers them onto the CDB ports. Those ports are snooped by the reservation stations, the PRF write port and the ROB.

---
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 tb/tb_cdb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-requester result FIFOs feeding CDB_WIDTH registered
// broadcast ports through a rotating-priority grant.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned CDB_WIDTH  = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ROB_IDX_W  = 5,
  parameter int unsigned PRF_IDX_W  = 6,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_id,
  input  logic [NUM_REQ*PRF_IDX_W-1:0]   req_rd_phy,
  input  logic [NUM_REQ*DATA_W-1:0]      req_rd_value,
  output logic [CDB_WIDTH-1:0]           cdb_valid,
  output logic [CDB_WIDTH*ROB_IDX_W-1:0] cdb_rob_id,
  output logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_rd_phy,
  output logic [CDB_WIDTH*DATA_W-1:0]    cdb_rd_value
);

  localparam int unsigned REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ROB_IDX_W-1:0] mem_rob   [NUM_REQ][FIFO_DEPTH];
  logic [PRF_IDX_W-1:0] mem_phy   [NUM_REQ][FIFO_DEPTH];
  logic [DATA_W-1:0]    mem_value [NUM_REQ][FIFO_DEPTH];

  logic [PTR_W-1:0]     rd_ptr    [NUM_REQ];
  logic [PTR_W-1:0]     wr_ptr    [NUM_REQ];
  logic [CNT_W-1:0]     count     [NUM_REQ];
  logic [CNT_W-1:0]     count_nxt [NUM_REQ];

  logic [REQ_W-1:0]     prio;
  logic [REQ_W-1:0]     prio_nxt;
  logic [NUM_REQ-1:0]   push;
  logic [NUM_REQ-1:0]   grant;
  logic [CDB_WIDTH-1:0] port_used;
  logic [REQ_W-1:0]     port_sel  [CDB_WIDTH];

  assign push = req_valid & req_ready;

  // Rotating scan from prio; the k-th non-empty FIFO found drives port k.
  always_comb begin
    logic [REQ_W-1:0] idx;
    int unsigned      n;
    grant     = '0;
    port_used = '0;
    prio_nxt  = prio;
    idx       = '0;
    n         = 0;
    for (int unsigned p = 0; p < CDB_WIDTH; p++) port_sel[p] = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = REQ_W'((32'(prio) + k) % NUM_REQ);
      if ((count[idx] != '0) && (n < CDB_WIDTH)) begin
        grant[idx] = 1'b1;
        for (int unsigned p = 0; p < CDB_WIDTH; p++) begin
          if (p == n) begin
            port_used[p] = 1'b1;
            port_sel[p]  = idx;
          end
        end
        prio_nxt = REQ_W'((32'(idx) + 32'd1) % NUM_REQ);
        n++;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      count_nxt[i] = count[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
    end
  end

  // Control state: counts, FIFO pointers, priority pointer, valid and ready flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= '0;
      cdb_valid <= '0;
      req_ready <= '1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else if (flush) begin
      cdb_valid <= '0;
      req_ready <= '1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      prio      <= prio_nxt;
      cdb_valid <= port_used;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        count[i]     <= count_nxt[i];
        req_ready[i] <= (count_nxt[i] != CNT_W'(FIFO_DEPTH));
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
      end
    end
  end

  // Payload storage and CDB payload registers carry no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (push[i] && !flush) begin
        mem_rob[i][wr_ptr[i]]   <= req_rob_id[i*ROB_IDX_W +: ROB_IDX_W];
        mem_phy[i][wr_ptr[i]]   <= req_rd_phy[i*PRF_IDX_W +: PRF_IDX_W];
        mem_value[i][wr_ptr[i]] <= req_rd_value[i*DATA_W +: DATA_W];
      end
    end
    for (int unsigned p = 0; p < CDB_WIDTH; p++) begin
      cdb_rob_id[p*ROB_IDX_W +: ROB_IDX_W]   <= mem_rob[port_sel[p]][rd_ptr[port_sel[p]]];
      cdb_rd_phy[p*PRF_IDX_W +: PRF_IDX_W]   <= mem_phy[port_sel[p]][rd_ptr[port_sel[p]]];
      cdb_rd_value[p*DATA_W +: DATA_W]       <= mem_value[port_sel[p]][rd_ptr[port_sel[p]]];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int NR = 4;
  localparam int CW = 2;
  localparam int FD = 2;
  localparam int RW = 5;
  localparam int PW = 6;
  localparam int DW = 32;
  localparam int EW = RW + PW + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*RW-1:0]  req_rob_id;
  logic [NR*PW-1:0]  req_rd_phy;
  logic [NR*DW-1:0]  req_rd_value;
  logic [CW-1:0]     cdb_valid;
  logic [CW*RW-1:0]  cdb_rob_id;
  logic [CW*PW-1:0]  cdb_rd_phy;
  logic [CW*DW-1:0]  cdb_rd_value;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_REQ(NR), .CDB_WIDTH(CW), .FIFO_DEPTH(FD),
    .ROB_IDX_W(RW), .PRF_IDX_W(PW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rob_id(req_rob_id), .req_rd_phy(req_rd_phy), .req_rd_value(req_rd_value),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_rd_phy(cdb_rd_phy), .cdb_rd_value(cdb_rd_value)
  );

  typedef struct packed {
    logic [CW-1:0]    v;
    logic [NR-1:0]    rdy;
    logic [CW*EW-1:0] pay;
  } exp_t;

  exp_t          expq[$];
  logic [EW-1:0] mq[NR][$];
  int            mptr = 0;
  int            checks = 0;
  int            errors = 0;
  int            seq[NR];

  // Reference: per-requester queues, scan from mptr, grant up to CW heads, then accept pushes.
  task automatic model_step();
    exp_t          e;
    logic [NR-1:0] rdy_pre;
    int            nslot;
    int            last;
    int            i;
    e = '0;
    rdy_pre = '0;
    if (rst) begin
      for (int r = 0; r < NR; r++) mq[r].delete();
      mptr = 0;
    end else if (flush) begin
      for (int r = 0; r < NR; r++) mq[r].delete();
    end else begin
      for (int r = 0; r < NR; r++) rdy_pre[r] = (mq[r].size() != FD);
      nslot = 0;
      last = -1;
      for (int k = 0; k < NR; k++) begin
        i = (mptr + k) % NR;
        if (mq[i].size() > 0 && nslot < CW) begin
          e.pay[nslot*EW +: EW] = mq[i].pop_front();
          e.v[nslot] = 1'b1;
          last = i;
          nslot++;
        end
      end
      if (last >= 0) mptr = (last + 1) % NR;
      for (int r = 0; r < NR; r++) begin
        if (req_valid[r] && rdy_pre[r])
          mq[r].push_back({req_rob_id[r*RW +: RW], req_rd_phy[r*PW +: PW], req_rd_value[r*DW +: DW]});
      end
    end
    for (int r = 0; r < NR; r++) e.rdy[r] = (mq[r].size() != FD);
    expq.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_payload();
    for (int r = 0; r < NR; r++) begin
      seq[r] = (seq[r] + 1) % 32;
      req_rob_id[r*RW +: RW]   = RW'(seq[r]);
      req_rd_phy[r*PW +: PW]   = PW'($urandom);
      req_rd_value[r*DW +: DW] = $urandom;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      req_valid = '0;
      rand_payload();
      tick();
    end
  endtask

  task automatic drive(input logic [NR-1:0] v, input int n);
    for (int c = 0; c < n; c++) begin
      req_valid = v;
      rand_payload();
      tick();
    end
  endtask

  // Monitor: one expected record per cycle, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        checks++;
        if (cdb_valid !== e.v) begin
          errors++;
          $display("FAIL cdb_valid: got %b expected %b at %0t", cdb_valid, e.v, $time);
        end
        checks++;
        if (req_ready !== e.rdy) begin
          errors++;
          $display("FAIL req_ready: got %b expected %b at %0t", req_ready, e.rdy, $time);
        end
        for (int p = 0; p < CW; p++) begin
          if (e.v[p]) begin
            checks++;
            if ({cdb_rob_id[p*RW +: RW], cdb_rd_phy[p*PW +: PW], cdb_rd_value[p*DW +: DW]}
                !== e.pay[p*EW +: EW]) begin
              errors++;
              $display("FAIL cdb_payload port %0d: got rob %0d phy %0d val %h expected rob %0d phy %0d val %h at %0t",
                       p, cdb_rob_id[p*RW +: RW], cdb_rd_phy[p*PW +: PW], cdb_rd_value[p*DW +: DW],
                       e.pay[p*EW+DW+PW +: RW], e.pay[p*EW+DW +: PW], e.pay[p*EW +: DW], $time);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < NR; r++) seq[r] = r * 8;
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '1;
    rand_payload();
    tick();
    tick();
    rst = 1'b0;
    idle(3);

    // Single result on requester 2
    req_valid = 4'b0100;
    req_rob_id[2*RW +: RW]   = 5'd7;
    req_rd_phy[2*PW +: PW]   = 6'd12;
    req_rd_value[2*DW +: DW] = 32'hDEADBEEF;
    tick();
    idle(4);

    // Saturation and sustained backpressure
    drive(4'b1111, 20);
    idle(6);
    drive(4'b1000, 6);
    drive(4'b1111, 6);
    idle(6);

    // Flush with a concurrent push on requester 1
    drive(4'b1111, 4);
    flush = 1'b1;
    req_valid = 4'b0010;
    rand_payload();
    tick();
    flush = 1'b0;
    idle(4);

    // Drive ptr to 3, then requesters 3 and 0 together, then 1,2,3
    drive(4'b0100, 1);
    idle(2);
    drive(4'b1001, 1);
    idle(2);
    drive(4'b1110, 1);
    idle(4);

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 600; c++) begin
      req_valid = NR'($urandom);
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      rand_payload();
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    idle(8);

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
